piso_tx: RTL and testbench



---
 rtl/piso_tx.sv | 111 +++++++++++
 tb/tb_piso_tx.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with optional start/stop framing; one bit per clock.
// A load is taken only in IDLE, including the done cycle, so frames can run back-to-back.
module piso_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit FRAME     = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           din,
  input  logic                       load,
  output logic                       ready,
  output logic                       op,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);

  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sreg_q;
  logic             op_q;
  logic             done_q;
  logic [CW-1:0]    cnt_q;

  logic             last_bit;

  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Vacated positions fill with 0 so the register drains to zero by frame end.
  function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign last_bit = (cnt_q == CW'(WIDTH-1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      op_q    <= FRAME;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load) begin
            cnt_q <= '0;
            if (FRAME) begin
              sreg_q  <= din;
              op_q    <= 1'b0;
              state_q <= START;
            end else begin
              // Unframed: first data bit goes out on the accepting edge.
              sreg_q  <= shift1(din);
              op_q    <= head(din);
              state_q <= DATA;
            end
          end
        end
        START: begin
          op_q    <= head(sreg_q);
          sreg_q  <= shift1(sreg_q);
          state_q <= DATA;
        end
        DATA: begin
          if (last_bit) begin
            if (FRAME) begin
              op_q    <= 1'b1;
              cnt_q   <= CW'(WIDTH);
              state_q <= STOP;
            end else begin
              op_q    <= 1'b0;
              cnt_q   <= '0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end else begin
            op_q   <= head(sreg_q);
            sreg_q <= shift1(sreg_q);
            cnt_q  <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          op_q    <= 1'b1;
          cnt_q   <= '0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          op_q    <= FRAME;
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready   = (state_q == IDLE);
  assign busy    = ~ready;
  assign op      = op_q;
  assign done    = done_q;
  assign bit_cnt = cnt_q;

endmodule

// File: tb/tb_piso_tx.sv
// Directed vector bench: framed MSB-first instance (a) and unframed LSB-first instance (b).
module tb_piso_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] din_a, din_b;
  logic       load_a, load_b;
  logic       rdy_a, op_a, busy_a, done_a;
  logic       rdy_b, op_b, busy_b, done_b;
  logic [2:0] cnt_a, cnt_b;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1), .FRAME(1'b1)) u_a (
    .clk(clk), .reset(reset), .din(din_a), .load(load_a), .ready(rdy_a),
    .op(op_a), .busy(busy_a), .done(done_a), .bit_cnt(cnt_a)
  );

  piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0), .FRAME(1'b0)) u_b (
    .clk(clk), .reset(reset), .din(din_b), .load(load_b), .ready(rdy_b),
    .op(op_b), .busy(busy_b), .done(done_b), .bit_cnt(cnt_b)
  );

  typedef struct {
    logic       sel;   // 0 = instance a, 1 = instance b
    logic       load;
    logic [3:0] din;
    logic       op;
    logic       rdy;
    logic       dn;
    logic [2:0] cnt;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic sel, input logic ld, input logic [3:0] d,
                              input logic o, input logic r, input logic dn, input logic [2:0] c);
    vec_t v;
    v.sel = sel; v.load = ld; v.din = d; v.op = o; v.rdy = r; v.dn = dn; v.cnt = c;
    return v;
  endfunction

  task automatic chk(input string nm, input logic o, input logic r, input logic b,
                     input logic d, input logic [2:0] c, input vec_t e);
    vecs++;
    if (o !== e.op || r !== e.rdy || b !== ~e.rdy || d !== e.dn || c !== e.cnt) begin
      errs++;
      $display("FAIL %s: got op=%b rdy=%b busy=%b done=%b cnt=%0d, want op=%b rdy=%b busy=%b done=%b cnt=%0d",
               nm, o, r, b, d, c, e.op, e.rdy, ~e.rdy, e.dn, e.cnt);
    end
  endtask

  task automatic check_now(input string nm, input vec_t v);
    if (!v.sel) chk(nm, op_a, rdy_a, busy_a, done_a, cnt_a, v);
    else        chk(nm, op_b, rdy_b, busy_b, done_b, cnt_b, v);
  endtask

  task automatic apply(input string nm, input vec_t v);
    @(negedge clk);
    if (!v.sel) begin
      load_a = v.load; din_a = v.din; load_b = 1'b0;
    end else begin
      load_b = v.load; din_b = v.din; load_a = 1'b0;
    end
    @(posedge clk);
    #1;
    check_now(nm, v);
  endtask

  initial begin
    // Instance a: idle, frame 1011, then A and 5 back-to-back with ignored mid-frame loads.
    for (int i = 0; i < 5; i++) tv.push_back(mk(0, 0, 4'h0, 1, 1, 0, 0));
    tv.push_back(mk(0, 1, 4'hB, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 4'hF, 1, 0, 0, 0));
    tv.push_back(mk(0, 0, 4'h0, 0, 0, 0, 1));
    tv.push_back(mk(0, 1, 4'hF, 1, 0, 0, 2));
    tv.push_back(mk(0, 0, 4'h0, 1, 0, 0, 3));
    tv.push_back(mk(0, 0, 4'h0, 1, 0, 0, 4));
    tv.push_back(mk(0, 0, 4'h0, 1, 1, 1, 0));
    tv.push_back(mk(0, 1, 4'hA, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 4'h0, 1, 0, 0, 0));
    tv.push_back(mk(0, 1, 4'hF, 0, 0, 0, 1));
    tv.push_back(mk(0, 0, 4'h0, 1, 0, 0, 2));
    tv.push_back(mk(0, 0, 4'h0, 0, 0, 0, 3));
    tv.push_back(mk(0, 0, 4'h0, 1, 0, 0, 4));
    tv.push_back(mk(0, 0, 4'h0, 1, 1, 1, 0));
    tv.push_back(mk(0, 1, 4'h5, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 4'h0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 4'h0, 1, 0, 0, 1));
    tv.push_back(mk(0, 0, 4'h0, 0, 0, 0, 2));
    tv.push_back(mk(0, 0, 4'h0, 1, 0, 0, 3));
    tv.push_back(mk(0, 0, 4'h0, 1, 0, 0, 4));
    tv.push_back(mk(0, 0, 4'h0, 1, 1, 1, 0));
    tv.push_back(mk(0, 0, 4'h0, 1, 1, 0, 0));
    // Instance b: unframed LSB-first 1000, then 0110 loaded in the done cycle.
    tv.push_back(mk(1, 0, 4'h0, 0, 1, 0, 0));
    tv.push_back(mk(1, 1, 4'h8, 0, 0, 0, 0));
    tv.push_back(mk(1, 0, 4'hF, 0, 0, 0, 1));
    tv.push_back(mk(1, 0, 4'h0, 0, 0, 0, 2));
    tv.push_back(mk(1, 0, 4'h0, 1, 0, 0, 3));
    tv.push_back(mk(1, 0, 4'h0, 0, 1, 1, 0));
    tv.push_back(mk(1, 1, 4'h6, 0, 0, 0, 0));
    tv.push_back(mk(1, 0, 4'h0, 1, 0, 0, 1));
    tv.push_back(mk(1, 1, 4'hF, 1, 0, 0, 2));
    tv.push_back(mk(1, 0, 4'h0, 0, 0, 0, 3));
    tv.push_back(mk(1, 0, 4'h0, 0, 1, 1, 0));
    tv.push_back(mk(1, 0, 4'h0, 0, 1, 0, 0));

    reset = 1'b1; load_a = 1'b0; load_b = 1'b0; din_a = '0; din_b = '0;
    #1;
    check_now("reset_a", mk(0, 0, 4'h0, 1, 1, 0, 0));
    check_now("reset_b", mk(1, 0, 4'h0, 0, 1, 0, 0));
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < tv.size(); i++) apply($sformatf("vec%0d", i), tv[i]);

    // Asynchronous reset in the middle of the third data bit of a framed word.
    apply("abort_load",  mk(0, 1, 4'hB, 0, 0, 0, 0));
    apply("abort_bit0",  mk(0, 0, 4'h0, 1, 0, 0, 0));
    apply("abort_bit1",  mk(0, 0, 4'h0, 0, 0, 0, 1));
    apply("abort_bit2",  mk(0, 0, 4'h0, 1, 0, 0, 2));
    #2 reset = 1'b1;
    #1;
    check_now("async_rst_a", mk(0, 0, 4'h0, 1, 1, 0, 0));
    check_now("async_rst_b", mk(1, 0, 4'h0, 0, 1, 0, 0));
    @(posedge clk);
    #1;
    check_now("rst_hold_a", mk(0, 0, 4'h0, 1, 1, 0, 0));
    @(negedge clk);
    reset = 1'b0;
    apply("post_rst_idle0", mk(0, 0, 4'h0, 1, 1, 0, 0));
    apply("post_rst_idle1", mk(0, 0, 4'h0, 1, 1, 0, 0));
    apply("refr_start",     mk(0, 1, 4'h6, 0, 0, 0, 0));
    apply("refr_bit0",      mk(0, 0, 4'h0, 0, 0, 0, 0));
    apply("refr_bit1",      mk(0, 0, 4'h0, 1, 0, 0, 1));
    apply("refr_bit2",      mk(0, 0, 4'h0, 1, 0, 0, 2));
    apply("refr_bit3",      mk(0, 0, 4'h0, 0, 0, 0, 3));
    apply("refr_stop",      mk(0, 0, 4'h0, 1, 0, 0, 4));
    apply("refr_done",      mk(0, 0, 4'h0, 1, 1, 1, 0));
    apply("refr_idle",      mk(0, 0, 4'h0, 1, 1, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
